// File: rtl/pe_skew_feeder.sv
// Requantising, FIFO-buffered operand feeder that skews each vector diagonally onto a PE array edge.
// Latency: vector pushed at cycle t into an idle empty feeder shows lane k valid at t+2+k.
// Backpressure: in_ready = !full (no look-ahead); output side never stalls. Define PE_FEEDER_SAT_EN to saturate instead of wrap.
module pe_skew_feeder #(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10,
  parameter int MUL_BW = 1 + INT_BW + FRA_BW,
  parameter int ACC_BW = 32,
  parameter int LANES  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ACC_BW-1:0]   in_data,
  input  logic                      in_last,
  output logic [LANES*MUL_BW-1:0]   out_data,
  output logic [LANES-1:0]          out_valid,
  output logic                      out_last,
  output logic                      busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LANES) + 1;
  localparam int ENT_W = LANES*MUL_BW + 1;
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_flush_cnt, w_cnt_nxt;
  logic [PTR_W:0]          r_wr_ptr, r_rd_ptr;
  logic [ENT_W-1:0]        r_mem [DEPTH];
  logic [LANES-1:0]        r_last_pipe;

  logic                    w_empty, w_full, w_push, w_pop;
  logic [LANES*MUL_BW-1:0] w_wr_vec, w_rd_vec;
  logic [ENT_W-1:0]        w_rd_ent;
  logic                    w_rd_last;

  // Requantise each lane at push time: drop FRA_BW fraction bits, then wrap or clamp.
  for (genvar k = 0; k < LANES; k++) begin : g_conv
    logic signed [ACC_BW-1:0] w_t;
    logic [MUL_BW-1:0]        w_conv;
    assign w_t = $signed(in_data[k*ACC_BW +: ACC_BW]) >>> FRA_BW;
`ifdef PE_FEEDER_SAT_EN
    localparam logic signed [ACC_BW-1:0] SAT_MAX = {{(ACC_BW-MUL_BW+1){1'b0}}, {(MUL_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] SAT_MIN = {{(ACC_BW-MUL_BW+1){1'b1}}, {(MUL_BW-1){1'b0}}};
    // Clamp out-of-range values to the most positive / most negative output word.
    always_comb begin
      w_conv = w_t[MUL_BW-1:0];
      if (w_t > SAT_MAX)
        w_conv = {1'b0, {(MUL_BW-1){1'b1}}};
      else if (w_t < SAT_MIN)
        w_conv = {1'b1, {(MUL_BW-1){1'b0}}};
    end
`else
    logic w_unused_hi;
    assign w_unused_hi = ^w_t[ACC_BW-1:MUL_BW];
    assign w_conv      = w_t[MUL_BW-1:0];
`endif
    assign w_wr_vec[k*MUL_BW +: MUL_BW] = w_conv;
  end

  // FIFO status: the extra pointer bit separates full from empty.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign in_ready  = !w_full;
  assign w_push    = in_valid && !w_full;
  assign w_rd_ent  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_rd_vec  = w_rd_ent[LANES*MUL_BW-1:0];
  assign w_rd_last = w_rd_ent[LANES*MUL_BW];

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {in_last, w_wr_vec};
  end

  // FIFO pointers advance on push and pop independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // FSM state and flush counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_cnt_nxt;
    end
  end

  // Next state and pop decision. IDLE pops in the same cycle it sees data so that a
  // fresh vector costs only one FIFO cycle. flush_cnt counts down the cycles until the
  // next tile's lane 0 may land; leaving FLUSH at 2 lets the IDLE pop that follows put
  // lane 0 out exactly when the count would reach zero, alongside the old tile's last lane.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_flush_cnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE, S_STREAM: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_STREAM;
          if (w_rd_last) begin
            w_cnt_nxt   = CNT_W'(LANES-1);
            w_state_nxt = (LANES > 2) ? S_FLUSH : S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        w_cnt_nxt = r_flush_cnt - CNT_W'(1);
        if (r_flush_cnt <= CNT_W'(2))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Skew pipes: lane k is k+1 stages deep; bubbles carry valid=0 and data=0.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [MUL_BW-1:0] r_dat [0:k];
    logic              r_vld [0:k];
    // Shift one stage per cycle, loading stage 0 from the popped vector or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= k; j++) begin
          r_dat[j] <= '0;
          r_vld[j] <= 1'b0;
        end
      end else begin
        r_dat[0] <= w_pop ? w_rd_vec[k*MUL_BW +: MUL_BW] : '0;
        r_vld[0] <= w_pop;
        for (int j = 1; j <= k; j++) begin
          r_dat[j] <= r_dat[j-1];
          r_vld[j] <= r_vld[j-1];
        end
      end
    end
    assign out_data[k*MUL_BW +: MUL_BW] = r_dat[k];
    assign out_valid[k]                 = r_vld[k];
  end

  // The last flag travels alongside the deepest lane only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last_pipe <= '0;
    else
      r_last_pipe <= {r_last_pipe[LANES-2:0], w_pop && w_rd_last};
  end

  assign out_last = r_last_pipe[LANES-1];
  assign busy     = (r_state != S_IDLE) || !w_empty || (|out_valid);

endmodule

// File: tb/tb_pe_skew_feeder.sv
// Directed bench for pe_skew_feeder with a vector scoreboard and latency checks.
// Expected lanes are computed from the input words at push time and consumed per lane.
// Build with PE_FEEDER_SAT_EN defined to exercise the saturating variant.
module tb_pe_skew_feeder;
  localparam int INT_BW = 5;
  localparam int FRA_BW = 10;
  localparam int MUL_BW = 16;
  localparam int ACC_BW = 32;
  localparam int LANES  = 4;
  localparam int DEPTH  = 4;

  logic                    clk, rst_n, in_valid, in_ready, in_last, out_last, busy;
  logic [LANES*ACC_BW-1:0] in_data;
  logic [LANES*MUL_BW-1:0] out_data;
  logic [LANES-1:0]        out_valid;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_stall = 0;
  logic [LANES*MUL_BW:0] q_vec[$];
  int lane_idx [LANES];
  int q_v0_cyc[$];
  int q_vl_cyc[$];
  int q_last_cyc[$];

  pe_skew_feeder #(
    .INT_BW(INT_BW), .FRA_BW(FRA_BW), .MUL_BW(MUL_BW),
    .ACC_BW(ACC_BW), .LANES(LANES), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MUL_BW-1:0] conv(input logic [ACC_BW-1:0] w);
    logic signed [ACC_BW-1:0] t;
    t = $signed(w) >>> FRA_BW;
`ifdef PE_FEEDER_SAT_EN
    if (t > 32767)  return 16'h7FFF;
    if (t < -32768) return 16'h8000;
`endif
    return t[MUL_BW-1:0];
  endfunction

  function automatic logic [LANES*ACC_BW-1:0] mkvec(input int base);
    logic [LANES*ACC_BW-1:0] v;
    for (int k = 0; k < LANES; k++)
      v[k*ACC_BW +: ACC_BW] = ACC_BW'((base + k) << FRA_BW);
    return v;
  endfunction

  // Scoreboard: every lane consumes expected vectors in push order.
  always @(negedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (out_valid[k]) begin
        if (k == 0) q_v0_cyc.push_back(cyc);
        if (k == LANES-1) q_vl_cyc.push_back(cyc);
        chk("sb_have_exp", (lane_idx[k] < q_vec.size()) ? 32'd1 : 32'd0, 32'd1);
        if (lane_idx[k] < q_vec.size()) begin
          chk("sb_lane_dat", 32'(out_data[k*MUL_BW +: MUL_BW]),
              32'(q_vec[lane_idx[k]][k*MUL_BW +: MUL_BW]));
          if (k == LANES-1)
            chk("sb_last", 32'(out_last), 32'(q_vec[lane_idx[k]][LANES*MUL_BW]));
          lane_idx[k]++;
        end
      end else begin
        chk("bubble_dat", 32'(out_data[k*MUL_BW +: MUL_BW]), 32'h0);
        if (k == LANES-1) chk("bubble_last", 32'(out_last), 32'h0);
      end
    end
    if (out_last) q_last_cyc.push_back(cyc);
  end

  task automatic push(input logic [LANES*ACC_BW-1:0] d, input logic l, output int pcyc);
    logic [LANES*MUL_BW:0] e;
    logic acc;
    int   waited;
    waited   = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      acc  = in_ready;
      pcyc = cyc;
      if (!acc) n_stall++;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 50);
    chk("push_accept", 32'(acc), 32'd1);
    if (acc) begin
      e[LANES*MUL_BW] = l;
      for (int k = 0; k < LANES; k++)
        e[k*MUL_BW +: MUL_BW] = conv(d[k*ACC_BW +: ACC_BW]);
      q_vec.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_lane(input int k, input logic [MUL_BW-1:0] exp, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid[k] && n < 20);
    chk({tag, "_seen"}, 32'(out_valid[k]), 32'd1);
    chk(tag, 32'(out_data[k*MUL_BW +: MUL_BW]), 32'(exp));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 100);
    chk("idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drained();
    for (int k = 0; k < LANES; k++)
      chk("drained", 32'(lane_idx[k]), 32'(q_vec.size()));
    q_vec.delete();
    for (int k = 0; k < LANES; k++) lane_idx[k] = 0;
  endtask

  task automatic clear_rec();
    q_v0_cyc.delete();
    q_vl_cyc.delete();
    q_last_cyc.delete();
  endtask

`ifdef PE_FEEDER_SAT_EN
  localparam logic [MUL_BW-1:0] SAT_E0 = 16'h7FFF;
  localparam logic [MUL_BW-1:0] SAT_E1 = 16'h8000;
`else
  localparam logic [MUL_BW-1:0] SAT_E0 = 16'h0000;
  localparam logic [MUL_BW-1:0] SAT_E1 = 16'h0000;
`endif

  initial begin
    int c;
    int rel;
    int p [8];
    logic [LANES*ACC_BW-1:0] d;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    for (int k = 0; k < LANES; k++) lane_idx[k] = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data != '0), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Single 1.0 vector with last: lane k at c+2+k, out_last with lane LANES-1.
    d = {LANES{32'h0010_0000}};
    push(d, 1'b1, c);
    for (int i = 1; i <= LANES + 3; i++) begin
      @(negedge clk);
      rel = cyc - c;
      chk("t1_vld", 32'(out_valid), (rel >= 2 && rel < 2+LANES) ? (32'd1 << (rel-2)) : 32'd0);
      chk("t1_last", 32'(out_last), (rel == 1+LANES) ? 32'd1 : 32'd0);
      chk("t1_busy", 32'(busy), (rel <= 1+LANES) ? 32'd1 : 32'd0);
      if (rel >= 2 && rel < 2+LANES)
        chk("t1_dat", 32'(out_data[(rel-2)*MUL_BW +: MUL_BW]), 32'h0400);
    end
    @(posedge clk); #1;
    wait_idle();
    drained();

    // Requantisation at the range edges.
    d = {32'h0010_0000, 32'h0000_0C00, 32'hF800_0000, 32'h0800_0000};
    push(d, 1'b1, c);
    wait_lane(0, SAT_E0, "sat_lane0");
    wait_lane(1, SAT_E1, "sat_lane1");
    wait_lane(2, 16'h0003, "sat_lane2");
    wait_lane(3, 16'h0400, "sat_lane3");
    wait_idle();
    drained();

    // Eight single-vector tiles with in_valid held: FIFO fills and in_ready throttles.
    clear_rec();
    n_stall = 0;
    for (int v = 0; v < 8; v++) begin
      d = mkvec(16*v + 1);
      push(d, 1'b1, p[v]);
    end
    wait_idle();
    chk("full_stalled", 32'(n_stall != 0), 32'd1);
    chk("full_count", 32'(q_v0_cyc.size()), 32'd8);
    drained();

    // Back-to-back tile of 6: one vector per cycle per lane.
    clear_rec();
    for (int v = 0; v < 6; v++) begin
      d = mkvec(16*v + 3);
      push(d, (v == 5), p[v]);
    end
    wait_idle();
    chk("tput_count", 32'(q_v0_cyc.size()), 32'd6);
    for (int v = 0; v < 6 && v < q_v0_cyc.size(); v++) begin
      chk("tput_push", 32'(p[v]), 32'(p[0] + v));
      chk("tput_lane0", 32'(q_v0_cyc[v]), 32'(p[v] + 2));
      chk("tput_laneN", 32'(q_vl_cyc[v]), 32'(p[v] + 1 + LANES));
    end
    drained();

    // Tile A (2 vectors) then tile B (2 vectors) back to back.
    clear_rec();
    push(mkvec(5), 1'b0, p[0]);
    push(mkvec(9), 1'b1, p[1]);
    push(mkvec(13), 1'b0, p[2]);
    push(mkvec(17), 1'b1, p[3]);
    wait_idle();
    chk("tile_count", 32'(q_v0_cyc.size()), 32'd4);
    chk("tile_last_n", 32'(q_last_cyc.size()), 32'd2);
    if (q_v0_cyc.size() == 4 && q_last_cyc.size() == 2) begin
      chk("tileA_lane0", 32'(q_v0_cyc[1]), 32'(p[1] + 2));
      chk("tileB_gap", 32'(q_v0_cyc[2] - q_v0_cyc[1]), 32'(LANES - 1));
      chk("tileA_last", 32'(q_last_cyc[0]), 32'(p[1] + 1 + LANES));
    end
    drained();

    // Gap of two cycles inside a tile: skewed 2-cycle bubble, feeder stays busy.
    clear_rec();
    push(mkvec(21), 1'b0, p[0]);
    push(mkvec(25), 1'b0, p[1]);
    repeat (2) begin
      @(negedge clk);
      chk("gap_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    push(mkvec(29), 1'b0, p[2]);
    push(mkvec(33), 1'b1, p[3]);
    wait_idle();
    chk("gap_push", 32'(p[2] - p[1]), 32'd3);
    chk("gap_count", 32'(q_vl_cyc.size()), 32'd4);
    for (int v = 0; v < 4 && v < q_vl_cyc.size(); v++) begin
      chk("gap_lane0", 32'(q_v0_cyc[v]), 32'(p[v] + 2));
      chk("gap_laneN", 32'(q_vl_cyc[v]), 32'(p[v] + 1 + LANES));
    end
    drained();

    // Reset with three vectors queued and two in the skew pipes.
    push(mkvec(41), 1'b1, p[0]);
    push(mkvec(45), 1'b1, p[1]);
    push(mkvec(49), 1'b0, p[2]);
    push(mkvec(53), 1'b0, p[3]);
    push(mkvec(57), 1'b0, p[4]);
    chk("rst_inflight", 32'(out_valid != '0), 32'd1);
    rst_n = 1'b0;
    q_vec.delete();
    for (int k = 0; k < LANES; k++) lane_idx[k] = 0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_data", 32'(out_data != '0), 32'd0);
    chk("rst_mid_last", 32'(out_last), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    clear_rec();
    repeat (12) begin @(posedge clk); #1; end
    chk("post_rst_out", 32'(q_v0_cyc.size() + q_vl_cyc.size()), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
